// File: rtl/rom2ram_pkg.sv
// rtl/rom2ram_pkg.sv - shared state, latched-config type and config check for rom2ram_dma2d
package rom2ram_pkg;

  // Config fields are stored at these widths; instances use the low bits they need.
  localparam int CFG_AW    = 16;
  localparam int CFG_DIM_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN,
    ERR
  } dma_state_e;

  typedef struct packed {
    logic [CFG_AW-1:0]    src_base;
    logic [CFG_AW-1:0]    src_stride;
    logic [CFG_AW-1:0]    dst_base;
    logic [CFG_AW-1:0]    dst_stride;
    logic [CFG_DIM_W-1:0] rows;
    logic [CFG_DIM_W-1:0] cols;
    logic                 transpose;
  } dma_cfg_t;

  function automatic logic cfg_valid(input logic [CFG_DIM_W-1:0] rows,
                                     input logic [CFG_DIM_W-1:0] cols,
                                     input logic [CFG_DIM_W-1:0] max_dim);
    return (rows != '0) && (cols != '0) && (rows <= max_dim) && (cols <= max_dim);
  endfunction

endpackage

// File: rtl/addr_gen_2d.sv
// rtl/addr_gen_2d.sv - 2-D address walker: row/col counters with a running row-base accumulator
module addr_gen_2d #(
  parameter int AW    = 8,
  parameter int DIM_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [AW-1:0]    base,
  input  logic [AW-1:0]    outer_step,
  input  logic [AW-1:0]    inner_step,
  input  logic [DIM_W-1:0] outer_n,
  input  logic [DIM_W-1:0] inner_n,
  output logic [AW-1:0]    addr,
  output logic             first,
  output logic             last
);

  logic [AW-1:0]    row_base;
  logic [AW-1:0]    next_row_base;
  logic [DIM_W-1:0] outer_idx;
  logic [DIM_W-1:0] inner_idx;
  logic             inner_end;

  assign inner_end     = (inner_idx == inner_n - DIM_W'(1));
  assign next_row_base = row_base + outer_step;
  assign first         = (outer_idx == '0) && (inner_idx == '0);
  assign last          = inner_end && (outer_idx == outer_n - DIM_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base  <= '0;
      addr      <= '0;
      outer_idx <= '0;
      inner_idx <= '0;
    end else if (load) begin
      row_base  <= base;
      addr      <= base;
      outer_idx <= '0;
      inner_idx <= '0;
    end else if (step) begin
      if (inner_end) begin
        row_base  <= next_row_base;
        addr      <= next_row_base;
        outer_idx <= outer_idx + DIM_W'(1);
        inner_idx <= '0;
      end else begin
        addr      <= addr + inner_step;
        inner_idx <= inner_idx + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/rom2ram_dma2d.sv
// rtl/rom2ram_dma2d.sv - 2-D tile copy from synchronous ROM to RAM; ROM2RAM_DMA2D_TRANSPOSE_EN adds column-major writes
module rom2ram_dma2d
  import rom2ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROM_DEPTH  = 256,
  parameter int RAM_DEPTH  = 256,
  parameter int MAX_DIM    = 16,
  localparam int ROM_AW    = $clog2(ROM_DEPTH),
  localparam int RAM_AW    = $clog2(RAM_DEPTH),
  localparam int DIM_W     = $clog2(MAX_DIM + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ROM_AW-1:0]     src_base,
  input  logic [ROM_AW-1:0]     src_stride,
  input  logic [RAM_AW-1:0]     dst_base,
  input  logic [RAM_AW-1:0]     dst_stride,
  input  logic [DIM_W-1:0]      rows,
  input  logic [DIM_W-1:0]      cols,
  input  logic                  transpose,
  output logic                  rom_en,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic                  ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2*DIM_W-1:0]    count
);

  localparam int CW = 2 * DIM_W;

  dma_state_e state, next_state;
  dma_cfg_t   cfg, cfg_in;

  logic              accept, cfg_ok, abort_hit, running;
  logic              src_first, src_last, dst_first, dst_last;
  logic [RAM_AW-1:0] dst_addr, dst_outer, dst_inner;
  logic              rom_en_d, ram_we_d, busy_d, done_d, err_d;
  logic [RAM_AW-1:0] ram_addr_d;
  logic [CW-1:0]     count_d;
  logic              unused_bits;

  always_comb begin
    cfg_in            = '0;
    cfg_in.src_base   = CFG_AW'(src_base);
    cfg_in.src_stride = CFG_AW'(src_stride);
    cfg_in.dst_base   = CFG_AW'(dst_base);
    cfg_in.dst_stride = CFG_AW'(dst_stride);
    cfg_in.rows       = CFG_DIM_W'(rows);
    cfg_in.cols       = CFG_DIM_W'(cols);
`ifdef ROM2RAM_DMA2D_TRANSPOSE_EN
    cfg_in.transpose  = transpose;
`else
    cfg_in.transpose  = 1'b0;
`endif
  end

  assign cfg_ok    = cfg_valid(cfg_in.rows, cfg_in.cols, CFG_DIM_W'(MAX_DIM));
  assign accept    = (state == IDLE) && start && !abort;
  assign abort_hit = abort && ((state == RUN) || (state == DRAIN));
  assign running   = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (accept) next_state = cfg_ok ? RUN : ERR;
      RUN:      if (abort) next_state = IDLE;
                else if (src_last) next_state = DRAIN;
      DRAIN:    next_state = abort ? IDLE : FIN;
      FIN, ERR: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead from next_state and registered below.
  always_comb begin
    rom_en_d   = (next_state == RUN);
    ram_we_d   = rom_en && !abort_hit;
    busy_d     = (next_state == RUN) || (next_state == DRAIN);
    done_d     = (next_state == FIN) || (next_state == ERR);
    err_d      = accept ? !cfg_ok : err;
    count_d    = accept ? '0 : count + CW'(ram_we);
    ram_addr_d = rom_en ? dst_addr : ram_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg      <= '0;
      rom_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= '0;
    end else begin
      if (accept) cfg <= cfg_in;
      rom_en   <= rom_en_d;
      ram_we   <= ram_we_d;
      ram_addr <= ram_addr_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      count    <= count_d;
    end
  end

  // The ROM output register already holds the element being written this cycle.
  assign ram_wdata = ram_we ? rom_rdata : '0;

  addr_gen_2d #(.AW(ROM_AW), .DIM_W(DIM_W)) u_src (
    .clk        (clk),
    .rst        (reset),
    .load       (accept),
    .step       (running),
    .base       (src_base),
    .outer_step (cfg.src_stride[ROM_AW-1:0]),
    .inner_step (ROM_AW'(1)),
    .outer_n    (cfg.rows[DIM_W-1:0]),
    .inner_n    (cfg.cols[DIM_W-1:0]),
    .addr       (rom_addr),
    .first      (src_first),
    .last       (src_last)
  );

`ifdef ROM2RAM_DMA2D_TRANSPOSE_EN
  // Transposed writes keep the row-major walk but swap which step is the stride.
  assign dst_outer = cfg.transpose ? RAM_AW'(1) : cfg.dst_stride[RAM_AW-1:0];
  assign dst_inner = cfg.transpose ? cfg.dst_stride[RAM_AW-1:0] : RAM_AW'(1);
`else
  logic unused_transpose;
  assign unused_transpose = transpose;
  assign dst_outer        = cfg.dst_stride[RAM_AW-1:0];
  assign dst_inner        = RAM_AW'(1);
`endif

  addr_gen_2d #(.AW(RAM_AW), .DIM_W(DIM_W)) u_dst (
    .clk        (clk),
    .rst        (reset),
    .load       (accept),
    .step       (running),
    .base       (dst_base),
    .outer_step (dst_outer),
    .inner_step (dst_inner),
    .outer_n    (cfg.rows[DIM_W-1:0]),
    .inner_n    (cfg.cols[DIM_W-1:0]),
    .addr       (dst_addr),
    .first      (dst_first),
    .last       (dst_last)
  );

  assign unused_bits = ^{cfg, src_first, dst_first, dst_last};

endmodule

// File: tb/tb_rom2ram_dma2d.sv
// tb/tb_rom2ram_dma2d.sv - scoreboard bench for rom2ram_dma2d (transpose case only with ROM2RAM_DMA2D_TRANSPOSE_EN)
module tb_rom2ram_dma2d;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, transpose = 1'b0;
  logic [7:0] src_base = '0, src_stride = '0, dst_base = '0, dst_stride = '0;
  logic [4:0] rows = '0, cols = '0;
  logic       rom_en, ram_we, busy, done, err;
  logic [7:0] rom_addr, ram_addr, ram_wdata;
  logic [7:0] rom_rdata = '0;
  logic [9:0] count;
  logic [7:0] rom [256];

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  ev_t rd_q[$], wr_q[$], dn_q[$];
  ev_t me;
  int  cyc = 0, t0 = 0, passed = 0, total = 0;

  rom2ram_dma2d dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_base(src_base), .src_stride(src_stride), .dst_base(dst_base), .dst_stride(dst_stride),
    .rows(rows), .cols(cols), .transpose(transpose),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rom_en) rom_rdata <= rom[rom_addr];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Monitor: interval k after the start edge is observed at the k-th following negedge.
  always @(negedge clk) if (!reset) begin
    if (rom_en) begin
      check("busy_while_reading", int'(busy), 1);
      if (rd_q.size() == 0) check("extra_read_at_cycle", cyc - t0, -1);
      else begin
        me = rd_q.pop_front();
        check("read_cycle", cyc - t0, me.cyc - t0);
        check("read_addr", int'(rom_addr), me.addr);
      end
    end
    if (ram_we) begin
      if (wr_q.size() == 0) check("extra_write_at_cycle", cyc - t0, -1);
      else begin
        me = wr_q.pop_front();
        check("write_cycle", cyc - t0, me.cyc - t0);
        check("write_addr", int'(ram_addr), me.addr);
        check("write_data", int'(ram_wdata), me.data);
      end
    end
    if (done) begin
      if (dn_q.size() == 0) check("extra_done_at_cycle", cyc - t0, -1);
      else begin
        me = dn_q.pop_front();
        check("done_cycle", cyc - t0, me.cyc - t0);
        check("done_count", int'(count), me.addr);
        check("done_err", int'(err), me.data);
        check("done_busy_low", int'(busy), 0);
      end
    end
  end

  // Issues one start and queues the hand-derived reads, writes and done expected from it.
  task automatic go(input int sb, input int ss, input int db, input int ds, input int r,
                    input int c, input int tr, input int nr, input int nw,
                    input int dcyc, input int dcnt, input int derr);
    int ra, wa, rr, cc;
    @(negedge clk);
    src_base = 8'(sb); src_stride = 8'(ss); dst_base = 8'(db); dst_stride = 8'(ds);
    rows = 5'(r); cols = 5'(c); transpose = tr[0]; start = 1'b1;
    t0 = cyc;
    for (int e = 0; e < nr; e++) begin
      rr = e / c; cc = e % c;
      ra = (sb + rr * ss + cc) & 255;
      rd_q.push_back('{t0 + 1 + e, ra, 0});
      if (e < nw) begin
        wa = (tr != 0) ? ((db + cc * ds + rr) & 255) : ((db + rr * ds + cc) & 255);
        wr_q.push_back('{t0 + 2 + e, wa, int'(rom[ra])});
      end
    end
    if (dcyc > 0) dn_q.push_back('{t0 + dcyc, dcnt, derr});
    @(negedge clk);
    start = 1'b0; transpose = 1'b0;
    src_base = 8'hEE; src_stride = 8'h77; dst_base = 8'hDD; dst_stride = 8'h11;
    rows = 5'd3; cols = 5'd5;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    check("reads_outstanding", rd_q.size(), 0);
    check("writes_outstanding", wr_q.size(), 0);
    check("done_outstanding", dn_q.size(), 0);
    rd_q.delete(); wr_q.delete(); dn_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i ^ 8'hA5);
    repeat (3) @(negedge clk);
    check("rst_rom_en", int'(rom_en), 0);
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_count", int'(count), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_wdata", int'(ram_wdata), 0);
    reset = 1'b0;

    // 4x4 basic copy: done in cycle N+2 = 18
    go(0, 4, 'h40, 4, 4, 4, 0, 16, 16, 18, 16, 0);
    settle(22);
    check("count_hold_after_done", int'(count), 16);

    // 2x3 strided sub-tile: reads 5,6,7,13,14,15, writes 0..5
    go(5, 8, 0, 3, 2, 3, 0, 6, 6, 8, 6, 0);
    settle(12);

    // config errors: rows=0 then cols=17; done+err in cycle 1, count cleared
    go(0, 4, 0, 4, 0, 4, 0, 0, 0, 1, 0, 1);
    settle(4);
    check("err_sticky", int'(err), 1);
    go(0, 4, 0, 4, 4, 17, 0, 0, 0, 1, 0, 1);
    settle(4);

    // abort sampled at the end of cycle 6: six reads, writes of cycles 2..6 land, no done
    go(0, 4, 'h40, 4, 4, 4, 0, 6, 5, 0, 0, 0);
    while (cyc < t0 + 6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_rom_en", int'(rom_en), 0);
    check("abort_ram_we", int'(ram_we), 0);
    check("abort_count", int'(count), 5);
    check("abort_err_cleared", int'(err), 0);
    settle(6);

    // normal transfer after abort
    go(1, 4, 'h20, 4, 2, 2, 0, 4, 4, 6, 4, 0);
    settle(8);

    // ROM address wrap, plus a start pulse during cycle 3 that must be ignored
    go(250, 8, 'h80, 0, 1, 8, 0, 8, 8, 10, 8, 0);
    while (cyc < t0 + 3) @(negedge clk);
    start = 1'b1; rows = 5'd1; cols = 5'd1; src_base = 8'h00;
    @(negedge clk);
    start = 1'b0;
    settle(12);

    // abort together with start in IDLE: nothing happens, count held
    @(negedge clk);
    start = 1'b1; abort = 1'b1; rows = 5'd2; cols = 5'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", int'(busy), 0);
    check("abort_start_count", int'(count), 8);
    settle(4);

`ifdef ROM2RAM_DMA2D_TRANSPOSE_EN
    // 2x3 transposed: ROM row 0 lands at dst 0,2,4
    go(0, 3, 0, 2, 2, 3, 1, 6, 6, 8, 6, 0);
    settle(12);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
